siphash_msg_packer: RTL and testbench

SIPHASH_MSG_PACKER -- requirements
Module: siphash_msg_packer

---
 rtl/siphash_msg_packer.sv | 168 ++++++++++++++++
 tb/tb_siphash_msg_packer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/siphash_msg_packer.sv
// ============================================================================
// siphash_msg_packer
// Packs a keyed byte stream into SipHash core commands: two key loads,
// little-endian 64-bit compress words, length-tagged final word, finalize.
// Revision: 1.0
// ============================================================================
`default_nettype none

module siphash_msg_packer (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic         key_empty,
    input  logic [7:0]   byte_data,
    input  logic         byte_valid,
    input  logic         byte_last,
    output logic         byte_ready,
    output logic [67:0]  cmd,
    output logic         cmd_we,
    input  logic         core_busy,
    output logic         done
);

    localparam logic [3:0] c_OP_KEY0 = 4'b0000;
    localparam logic [3:0] c_OP_KEY1 = 4'b0001;
    localparam logic [3:0] c_OP_CMP  = 4'b0010;
    localparam logic [3:0] c_OP_FIN  = 4'b0011;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_KEY0     = 4'd1,
        ST_KEY1     = 4'd2,
        ST_FILL     = 4'd3,
        ST_CMP      = 4'd4,
        ST_CMP_GAP  = 4'd5,
        ST_CMP_WAIT = 4'd6,
        ST_FINAL    = 4'd7,
        ST_FIN      = 4'd8,
        ST_DONE     = 4'd9
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_k0;
    logic [63:0] r_k1;
    logic        r_empty;
    logic [63:0] r_buf;
    logic [7:0]  r_len;
    logic        r_last;    // message ended on a full word; a final word follows
    logic        r_fin;     // current compress carries the length word
    logic [2:0]  w_pos;

    assign w_pos = r_len[2:0];

    always_comb begin
        w_state_nxt = r_state;
        key_ready   = 1'b0;
        byte_ready  = 1'b0;
        cmd_we      = 1'b0;
        cmd         = 68'h0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                key_ready = ~rst;
                if (key_valid) w_state_nxt = ST_KEY0;
            end
            ST_KEY0: begin
                if (!core_busy) begin
                    cmd_we      = 1'b1;
                    cmd         = {c_OP_KEY0, r_k0};
                    w_state_nxt = ST_KEY1;
                end
            end
            ST_KEY1: begin
                if (!core_busy) begin
                    cmd_we      = 1'b1;
                    cmd         = {c_OP_KEY1, r_k1};
                    w_state_nxt = r_empty ? ST_FINAL : ST_FILL;
                end
            end
            ST_FILL: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if (w_pos == 3'd7)  w_state_nxt = ST_CMP;
                    else if (byte_last) w_state_nxt = ST_FINAL;
                end
            end
            ST_CMP: begin
                if (!core_busy) begin
                    cmd_we      = 1'b1;
                    cmd         = {c_OP_CMP, r_buf};
                    w_state_nxt = ST_CMP_GAP;
                end
            end
            // Core asserts busy one cycle after accepting a compress.
            ST_CMP_GAP: w_state_nxt = ST_CMP_WAIT;
            ST_CMP_WAIT: begin
                if (!core_busy) begin
                    if (r_fin)       w_state_nxt = ST_FIN;
                    else if (r_last) w_state_nxt = ST_FINAL;
                    else             w_state_nxt = ST_FILL;
                end
            end
            ST_FINAL: w_state_nxt = ST_CMP;
            ST_FIN: begin
                if (!core_busy) begin
                    cmd_we      = 1'b1;
                    cmd         = {c_OP_FIN, 64'h0};
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_k0    <= 64'h0;
            r_k1    <= 64'h0;
            r_empty <= 1'b0;
            r_buf   <= 64'h0;
            r_len   <= 8'h0;
            r_last  <= 1'b0;
            r_fin   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (key_valid) begin
                        r_k0    <= key[63:0];
                        r_k1    <= key[127:64];
                        r_empty <= key_empty;
                        r_buf   <= 64'h0;
                        r_len   <= 8'h0;
                        r_last  <= 1'b0;
                        r_fin   <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (byte_valid) begin
                        r_buf[{w_pos, 3'b000} +: 8] <= byte_data;
                        r_len                       <= 8'(r_len + 8'd1);
                        if (w_pos == 3'd7) r_last <= byte_last;
                    end
                end
                ST_CMP_WAIT: begin
                    if (!core_busy) r_buf <= 64'h0;
                end
                // Bytes above the partial tail are already zero from the last clear.
                ST_FINAL: begin
                    r_buf[63:56] <= r_len;
                    r_fin        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_siphash_msg_packer.sv
// ============================================================================
// tb_siphash_msg_packer
// Randomized self-checking bench: byte stream vs. a word-level SipHash packing model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_siphash_msg_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key;
    logic         key_valid;
    logic         key_ready;
    logic         key_empty;
    logic [7:0]   byte_data;
    logic         byte_valid;
    logic         byte_last;
    logic         byte_ready;
    logic [67:0]  cmd;
    logic         cmd_we;
    logic         core_busy;
    logic         done;

    always #5 clk = ~clk;

    siphash_msg_packer u_dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_empty  (key_empty),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .cmd        (cmd),
        .cmd_we     (cmd_we),
        .core_busy  (core_busy),
        .done       (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    localparam logic [127:0] c_KEY = 128'h0f0e0d0c0b0a09080706050403020100;

    logic [7:0]   tx_q[$];
    logic [67:0]  obs_q[$];
    logic [67:0]  exp_q[$];
    int           tx_idx;
    int           done_cnt;
    bit           key_pending;
    logic [127:0] key_hold;
    bit           empty_hold;
    bit           msg_busy;
    int           busy_len;
    int           busy_cnt;
    bit           busy_arm;
    bit           noise;
    bit           check_no_rdy;

    // Reference: key loads, every full 8-byte group little-endian, then the
    // tail bytes with (length mod 256) in the top byte, then finalize.
    task automatic build_exp(input logic [127:0] k);
        int          n;
        logic [63:0] w;
        n = tx_q.size();
        exp_q.delete();
        exp_q.push_back({4'h0, k[63:0]});
        exp_q.push_back({4'h1, k[127:64]});
        for (int i = 0; i < n / 8; i++) begin
            w = 64'h0;
            for (int b = 0; b < 8; b++) w |= 64'(tx_q[8*i+b]) << (8*b);
            exp_q.push_back({4'h2, w});
        end
        w = 64'(n % 256) << 56;
        for (int b = 0; b < n % 8; b++) w |= 64'(tx_q[8*(n/8)+b]) << (8*b);
        exp_q.push_back({4'h2, w});
        exp_q.push_back({4'h3, 64'h0});
    endtask

    // One clock: drive inputs at the falling edge, sample 1 ns later.
    task automatic tick();
        @(negedge clk);
        if (busy_arm) begin
            busy_arm = 1'b0;
            busy_cnt = busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        core_busy = (busy_cnt > 0) || (noise && $urandom_range(0, 3) == 0);

        if (key_pending) begin
            key_valid = 1'b1;
            key       = key_hold;
            key_empty = empty_hold;
        end else if (msg_busy) begin
            key_valid = 1'($urandom_range(0, 1));
            key       = {$urandom, $urandom, $urandom, $urandom};
            key_empty = 1'($urandom_range(0, 1));
        end else begin
            key_valid = 1'b0;
        end

        if (msg_busy && tx_idx < tx_q.size()) begin
            byte_valid = ($urandom_range(0, 3) != 0);
            byte_data  = tx_q[tx_idx];
            byte_last  = (tx_idx == tx_q.size() - 1);
        end else begin
            byte_valid = msg_busy ? 1'($urandom_range(0, 1)) : 1'b0;
            byte_data  = 8'($urandom);
            byte_last  = 1'($urandom_range(0, 1));
        end

        #1;
        if (key_valid && key_ready && key_pending) begin
            key_pending = 1'b0;
            msg_busy    = 1'b1;
        end
        if (byte_valid && byte_ready && tx_idx < tx_q.size()) tx_idx++;

        if (cmd_we) obs_q.push_back(cmd);
        else        check("cmd_zero_when_idle", cmd, 68'h0);
        check("we_during_busy", 68'(cmd_we & core_busy), 68'h0);
        check("ready_during_busy", 68'(byte_ready & (busy_cnt > 0)), 68'h0);
        if (check_no_rdy) check("ready_on_empty", 68'(byte_ready), 68'h0);
        if (cmd_we && cmd[67:64] == 4'h2 && busy_len > 0) busy_arm = 1'b1;
        if (done) begin
            done_cnt++;
            msg_busy = 1'b0;
        end
    endtask

    task automatic start_msg(input logic [127:0] k, input int len, input int mode,
                             input int blen, input bit nz);
        tx_q.delete();
        for (int i = 0; i < len; i++) begin
            case (mode)
                1:       tx_q.push_back(8'(i));
                2:       tx_q.push_back(8'hAA);
                default: tx_q.push_back(8'($urandom));
            endcase
        end
        tx_idx       = 0;
        obs_q.delete();
        done_cnt     = 0;
        build_exp(k);
        key_hold     = k;
        empty_hold   = (len == 0);
        key_pending  = 1'b1;
        busy_len     = blen;
        noise        = nz;
        check_no_rdy = (len == 0);
    endtask

    task automatic run_msg(input logic [127:0] k, input int len, input int mode,
                           input int blen, input bit nz, input string tag);
        int cyc;
        start_msg(k, len, mode, blen, nz);
        cyc = 0;
        while (done_cnt == 0 && cyc < 6000) begin
            tick();
            cyc++;
        end
        check({tag, "_timeout"}, 68'(done_cnt == 0), 68'h0);
        noise = 1'b0;
        repeat (4) tick();
        check({tag, "_ncmd"}, 68'(obs_q.size()), 68'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_cmd%0d", tag, i),
                  (i < obs_q.size()) ? obs_q[i] : 68'h0, exp_q[i]);
        check({tag, "_done_pulses"}, 68'(done_cnt), 68'd1);
        check_no_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; key = '0; key_valid = 1'b0; key_empty = 1'b0;
        byte_data = '0; byte_valid = 1'b0; byte_last = 1'b0; core_busy = 1'b0;
        tx_idx = 0; done_cnt = 0; key_pending = 1'b0; key_hold = '0; empty_hold = 1'b0;
        msg_busy = 1'b0; busy_len = 0; busy_cnt = 0; busy_arm = 1'b0; noise = 1'b0;
        check_no_rdy = 1'b0;

        repeat (3) tick();
        check("rst_key_ready", 68'(key_ready), 68'h0);
        check("rst_byte_ready", 68'(byte_ready), 68'h0);
        check("rst_cmd_we", 68'(cmd_we), 68'h0);
        check("rst_done", 68'(done), 68'h0);
        rst = 1'b0;
        tick();
        check("post_rst_key_ready", 68'(key_ready), 68'h1);
        check("post_rst_cmd", cmd, 68'h0);

        run_msg(c_KEY, 3, 1, 0, 1'b0, "three_bytes");
        check("three_bytes_word", (obs_q.size() > 2) ? obs_q[2] : 68'h0,
              {4'h2, 64'h0300000000020100});
        run_msg(c_KEY, 8, 1, 0, 1'b0, "eight_bytes");
        run_msg(c_KEY, 0, 0, 0, 1'b0, "empty");
        run_msg(c_KEY, 8, 1, 5, 1'b0, "busy5");
        run_msg(c_KEY, 256, 2, 0, 1'b0, "wrap256");

        // Abort a 12-byte message while waiting out the first compress.
        begin
            int cyc;
            start_msg(c_KEY, 12, 1, 5, 1'b0);
            cyc = 0;
            while (obs_q.size() < 3 && cyc < 2000) begin
                tick();
                cyc++;
            end
            check("abort_reach_cmp", 68'(obs_q.size() >= 3), 68'h1);
            tick();
            tick();
            rst = 1'b1;
            busy_len = 0; busy_cnt = 0; busy_arm = 1'b0;
            msg_busy = 1'b0; tx_q.delete(); tx_idx = 0;
            tick();
            check("abort_rst_key_ready", 68'(key_ready), 68'h0);
            rst = 1'b0;
            repeat (20) tick();
            check("abort_no_more_cmd", 68'(obs_q.size()), 68'd3);
            check("abort_no_done", 68'(done_cnt), 68'd0);
        end
        run_msg(c_KEY, 12, 0, 3, 1'b0, "after_abort");

        for (int r = 0; r < 8; r++)
            run_msg({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 40), 0,
                    $urandom_range(0, 6), 1'b1, $sformatf("rand%0d", r));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
